fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding fetch, holds the fetched word for
// decode, and handles redirects, decode-side halts and imem ack timeouts.
module fetch_sequencer #(
  parameter int                   BUS_WIDTH    = 16,
  parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter int                   ACK_TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] pc_in,
  output logic [BUS_WIDTH-1:0] pc_next,
  output logic                 imem_req,
  output logic [BUS_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [BUS_WIDTH-1:0] imem_data,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [BUS_WIDTH-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect_valid,
  input  logic [BUS_WIDTH-1:0] redirect_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 halted,
  output logic                 fetch_err
);

  localparam int            CW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);
  localparam logic [CW-1:0] WAIT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_instr;
  logic [BUS_WIDTH-1:0] r_instr_pc;
  logic                 r_instr_valid;
  logic                 r_fetch_err;
  logic [CW-1:0]        r_wait;

  state_t               w_state_nxt;
  logic [BUS_WIDTH-1:0] w_instr_nxt;
  logic [BUS_WIDTH-1:0] w_instr_pc_nxt;
  logic                 w_instr_valid_nxt;
  logic                 w_fetch_err_nxt;
  logic [CW-1:0]        w_wait_nxt;
  logic [BUS_WIDTH-1:0] w_pc_next;

  // State register and held-instruction datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_REQ;
      r_instr       <= {BUS_WIDTH{1'b0}};
      r_instr_pc    <= {BUS_WIDTH{1'b0}};
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_wait        <= WAIT_ZERO;
    end else begin
      r_state       <= w_state_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_fetch_err   <= w_fetch_err_nxt;
      r_wait        <= w_wait_nxt;
    end
  end

  // Next-state, next-datapath and PC selection; a redirect outranks ack, accept and halt
  always_comb begin
    w_state_nxt       = r_state;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_fetch_err_nxt   = r_fetch_err;
    w_wait_nxt        = r_wait;
    w_pc_next         = pc_in;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_next         = redirect_target;
          w_instr_valid_nxt = 1'b0;
          w_wait_nxt        = WAIT_ZERO;
          w_state_nxt       = S_REQ;
        end else if (imem_ack) begin
          w_instr_nxt       = imem_data;
          w_instr_pc_nxt    = pc_in;
          w_instr_valid_nxt = 1'b1;
          w_pc_next         = pc_in + BUS_WIDTH'(1);
          w_wait_nxt        = WAIT_ZERO;
          w_state_nxt       = S_HOLD;
        end else if (r_wait == WAIT_LAST) begin
          w_fetch_err_nxt = 1'b1;
          w_wait_nxt      = WAIT_ZERO;
          w_state_nxt     = S_HALT;
        end else begin
          w_wait_nxt = r_wait + WAIT_ONE;
        end
      end
      S_HOLD: begin
        w_wait_nxt = WAIT_ZERO;
        if (redirect_valid) begin
          w_pc_next         = redirect_target;
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_REQ;
        end else if (instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = halt_req ? S_HALT : S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HALT: begin
        w_instr_valid_nxt = 1'b0;
        w_wait_nxt        = WAIT_ZERO;
        // A timed-out fetch stays parked until reset
        if (resume && !r_fetch_err) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      default: begin
        w_instr_valid_nxt = 1'b0;
        w_wait_nxt        = WAIT_ZERO;
        w_state_nxt       = S_REQ;
      end
    endcase
    if (!rst) begin
      w_pc_next = RESET_VECTOR;
    end else begin
      w_pc_next = w_pc_next;
    end
  end

  assign pc_next     = w_pc_next;
  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = pc_in;
  assign halted      = (r_state == S_HALT);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_fetch_sequencer;

  localparam logic [15:0] RV = 16'h0000;
  localparam int          TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  fetch_sequencer #(
    .BUS_WIDTH   (16),
    .RESET_VECTOR(RV),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .halted         (halted),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  // External PC register and instruction memory (word at address a is 0x1000+a)
  always @(posedge clk) pc_in <= pc_next;
  always_comb imem_data = 16'h1000 + imem_addr;

  // Transaction-level model: is an instruction held, is fetching stopped, misses so far
  bit          m_hold  = 1'b0;
  bit          m_stop  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_valid = 1'b0;
  int          m_miss  = 0;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_ipc   = 16'h0000;

  function automatic logic [15:0] exp_pc_next();
    if (!rst) return RV;
    if (!m_stop && redirect_valid) return redirect_target;
    if (!m_stop && !m_hold && imem_ack) return m_pc + 16'd1;
    return m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [15:0] nxt;
    nxt = exp_pc_next();
    if (!rst) begin
      m_hold = 1'b0; m_stop = 1'b0; m_err = 1'b0; m_valid = 1'b0;
      m_miss = 0; m_instr = 16'h0000; m_ipc = 16'h0000;
    end else if (!m_stop && redirect_valid) begin
      m_hold = 1'b0; m_valid = 1'b0; m_miss = 0;
    end else if (!m_stop && !m_hold) begin
      if (imem_ack) begin
        m_instr = 16'h1000 + m_pc; m_ipc = m_pc; m_valid = 1'b1; m_hold = 1'b1; m_miss = 0;
      end else begin
        m_miss = m_miss + 1;
        if (m_miss == TO) begin
          m_err = 1'b1; m_stop = 1'b1; m_miss = 0;
        end
      end
    end else if (m_hold) begin
      if (instr_ready) begin
        m_valid = 1'b0; m_hold = 1'b0; m_stop = halt_req;
      end
    end else if (resume && !m_err) begin
      m_stop = 1'b0;
    end
    m_pc = nxt;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_imem_req", imem_req, !m_stop && !m_hold);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_pc_next", pc_next, exp_pc_next());
      chk("m_halted", halted, m_stop);
      chk("m_instr_valid", instr_valid, m_valid);
      chk("m_instr", instr, m_instr);
      chk("m_instr_pc", instr_pc, m_ipc);
      chk("m_fetch_err", fetch_err, m_err);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = 16'h0000; halt_req = 1'b0; resume = 1'b0;
    cyc(); check_en = 1'b1; cyc();
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_pc_next", pc_next, RV);
    rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("seq_valid", instr_valid, 1'b1);
      chk("seq_pc", instr_pc, k);
      chk("seq_instr", instr, 16'h1000 + k);
      cyc();
      chk("seq_gap", instr_valid, 1'b0);
    end

    // halt on accept of the instruction at 0x0005
    cyc();
    chk("h_pc", instr_pc, 16'h0005);
    halt_req = 1'b1;
    cyc();
    chk("h_halted", halted, 1'b1);
    chk("h_req", imem_req, 1'b0);
    chk("h_addr", imem_addr, 16'h0006);
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 16'h0300;
    #1 chk("h_redir_pc_next", pc_next, 16'h0006);
    cyc();
    chk("h_still", halted, 1'b1);
    chk("h_addr2", imem_addr, 16'h0006);
    redirect_valid = 1'b0; resume = 1'b1;
    cyc();
    chk("h_resumed", halted, 1'b0);
    chk("h_fetch_addr", imem_addr, 16'h0006);
    resume = 1'b0;
    cyc();
    chk("h_instr_pc", instr_pc, 16'h0006);

    // wrap at 0xFFFF
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    cyc();
    chk("w_valid", instr_valid, 1'b0);
    chk("w_addr", imem_addr, 16'hFFFF);
    redirect_valid = 1'b0;
    #1 chk("w_pc_next", pc_next, 16'h0000);
    cyc();
    chk("w_instr_pc", instr_pc, 16'hFFFF);
    chk("w_instr", instr, 16'h0FFF);
    chk("w_pc_in", imem_addr, 16'h0000);

    // decode stall then redirect together with accept
    instr_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk("s_valid", instr_valid, 1'b1);
      chk("s_instr_pc", instr_pc, 16'hFFFF);
      chk("s_req", imem_req, 1'b0);
      chk("s_pc_next", pc_next, 16'h0000);
    end
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0040;
    cyc();
    chk("s_valid_drop", instr_valid, 1'b0);
    chk("s_addr", imem_addr, 16'h0040);

    // redirect coincident with ack in REQ
    redirect_target = 16'h0200;
    #1 chk("r_pc_next", pc_next, 16'h0200);
    cyc();
    chk("r_valid", instr_valid, 1'b0);
    chk("r_req", imem_req, 1'b1);
    chk("r_addr", imem_addr, 16'h0200);
    redirect_valid = 1'b0;
    cyc();
    chk("r_instr_pc", instr_pc, 16'h0200);
    chk("r_instr", instr, 16'h1200);

    // ack timeout
    cyc();
    chk("t_addr", imem_addr, 16'h0201);
    imem_ack = 1'b0;
    repeat (TO - 1) begin
      cyc();
      chk("t_no_err_yet", fetch_err, 1'b0);
    end
    cyc();
    chk("t_err", fetch_err, 1'b1);
    chk("t_halted", halted, 1'b1);
    chk("t_req", imem_req, 1'b0);
    resume = 1'b1;
    repeat (2) begin
      cyc();
      chk("t_resume_ignored", halted, 1'b1);
    end
    resume = 1'b0; rst = 1'b0;
    #1 chk("t_rst_pc_next", pc_next, RV);
    cyc();
    chk("t_err_clr", fetch_err, 1'b0);
    chk("t_halt_clr", halted, 1'b0);
    chk("t_addr_rv", imem_addr, 16'h0000);
    rst = 1'b1; imem_ack = 1'b1;
    cyc();
    chk("t_refetch", instr_pc, 16'h0000);
    chk("t_refetch_instr", instr, 16'h1000);

    // reset while holding an instruction
    instr_ready = 1'b0;
    cyc();
    chk("m_held", instr_valid, 1'b1);
    rst = 1'b0;
    cyc();
    chk("m_valid_clr", instr_valid, 1'b0);
    chk("m_instr_clr", instr, 16'h0000);
    rst = 1'b1; instr_ready = 1'b1;
    cyc();
    chk("m_first", instr_valid, 1'b1);
    chk("m_first_pc", instr_pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
